// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a 4-digit 7-segment display. Rotates a
//   one-hot digit select toward an external 4:1 digit mux, decodes the
//   value the mux returns, and drives active-low anodes/cathodes with a
//   dead interval at the start of each slot to suppress ghosting.
//
// Parameters
//   PRESCALE      clk cycles per digit slot (>= 2)
//   BLANK_CYCLES  dead cycles at the start of each slot (1 .. PRESCALE-1)
//
// Ports
//   clk         system clock
//   rst         synchronous active-high reset
//   en          display enable
//   sel[3:0]    one-hot digit select to the mux S input (registered)
//   num[3:0]    selected digit value
//   err         selected error flag
//   blank       selected blank flag
//   dec_point   selected decimal point
//   an[3:0]     anodes, active-low, an[i] = digit i
//   seg[6:0]    cathodes, active-low, {g,f,e,d,c,b,a}
//   dp_n        decimal-point cathode, active-low
//   frame_tick  one-cycle pulse when sel wraps from 1000 to 0001
module seg7_scan_driver #(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [3:0] sel,
  input  logic [3:0] num,
  input  logic       err,
  input  logic       blank,
  input  logic       dec_point,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp_n,
  output logic       frame_tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);

  // Decode one digit into {dp_n, seg}; err outranks blank, blank outranks num.
  function automatic logic [7:0] decode(input logic e, input logic b,
                                        input logic [3:0] n, input logic d);
    logic [6:0] g;
    if (e) begin
      decode = {1'b1, 7'b0000110};
    end else if (b) begin
      decode = {1'b1, 7'b1111111};
    end else begin
      case (n)
        4'h0:    g = 7'b1000000;
        4'h1:    g = 7'b1111001;
        4'h2:    g = 7'b0100100;
        4'h3:    g = 7'b0110000;
        4'h4:    g = 7'b0011001;
        4'h5:    g = 7'b0010010;
        4'h6:    g = 7'b0000010;
        4'h7:    g = 7'b1111000;
        4'h8:    g = 7'b0000000;
        4'h9:    g = 7'b0010000;
        4'hA:    g = 7'b0001000;
        4'hB:    g = 7'b0000011;
        4'hC:    g = 7'b1000110;
        4'hD:    g = 7'b0100001;
        4'hE:    g = 7'b0000110;
        4'hF:    g = 7'b0001110;
        default: g = 7'b1111111;
      endcase
      decode = {~d, g};
    end
  endfunction

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [3:0]    sel_nxt_s;
  logic [3:0]    an_nxt_s;
  logic          tick_nxt_s;
  logic [7:0]    dec_s;

  // Next slot counter, digit select, anode pattern and frame pulse.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    sel_nxt_s  = sel;
    tick_nxt_s = 1'b0;
    an_nxt_s   = 4'b1111;
    if (!en) begin
      // Disabled: park at the start of the held digit's slot.
      cnt_nxt_s = {CW{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s  = {CW{1'b0}};
      sel_nxt_s  = {sel[2:0], sel[3]};
      tick_nxt_s = (sel == 4'b1000);
    end else begin
      cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
    // Anodes follow the next-state counter so they switch on the same edge.
    if (en && (cnt_nxt_s >= CNT_ON)) begin
      an_nxt_s = ~sel_nxt_s;
    end else begin
      an_nxt_s = 4'b1111;
    end
  end

  // Segment decode of the currently presented mux inputs.
  always_comb begin
    dec_s = decode(err, blank, num, dec_point);
  end

  // Scan state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CW{1'b0}};
      sel        <= 4'b0001;
      an         <= 4'b1111;
      seg        <= 7'b1111111;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      sel        <= sel_nxt_s;
      an         <= an_nxt_s;
      seg        <= dec_s[6:0];
      dp_n       <= dec_s[7];
      frame_tick <= tick_nxt_s;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  localparam int P = 8;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       rst, en, rst2, en2;
  logic [3:0] num;
  logic       err, blank, dec_point;
  logic [3:0] sel, an, sel2, an2;
  logic [6:0] seg, seg2;
  logic       dp_n, frame_tick, dp_n2, tick2;

  always #5 clk = ~clk;

  seg7_scan_driver #(.PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .num(num), .err(err),
    .blank(blank), .dec_point(dec_point), .an(an), .seg(seg), .dp_n(dp_n),
    .frame_tick(frame_tick));

  seg7_scan_driver #(.PRESCALE(2), .BLANK_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .sel(sel2), .num(num), .err(err),
    .blank(blank), .dec_point(dec_point), .an(an2), .seg(seg2), .dp_n(dp_n2),
    .frame_tick(tick2));

  // Digit mux model: per-digit sources, or a direct override for decode tests.
  logic [3:0] num_a [4];
  logic       dp_a [4];
  logic       err_a [4];
  logic       blank_a [4];
  logic       direct;
  logic [3:0] d_num;
  logic       d_err, d_blank, d_dp;
  int         idx;

  always_comb begin
    case (sel)
      4'b0010: idx = 1;
      4'b0100: idx = 2;
      4'b1000: idx = 3;
      default: idx = 0;
    endcase
    if (direct) begin
      num = d_num; err = d_err; blank = d_blank; dec_point = d_dp;
    end else begin
      num = num_a[idx]; err = err_a[idx]; blank = blank_a[idx]; dec_point = dp_a[idx];
    end
  end

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp_n;
    logic       tick;
  } exp_t;

  exp_t q[$];
  int   m_cnt, m_dig;
  int   n_checks = 0, n_pass = 0;
  int   cyc2 = 0, last2 = 0, n_tick2 = 0;
  logic [6:0] af [6];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [7:0] exp_out(input logic e, input logic b,
                                         input logic [3:0] n, input logic d);
    logic [6:0] g;
    if (e) return {1'b1, 7'b0000110};
    if (b) return 8'hFF;
    case (n)
      4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;  default: g = 7'b0001110;
    endcase
    return {~d, g};
  endfunction

  // One clock: drive inputs, push the expected post-edge outputs, then pop and compare.
  task automatic step(input logic r, input logic e);
    exp_t       x;
    logic [3:0] xn;
    logic       xe, xb, xd;
    @(negedge clk);
    rst = r;
    en  = e;
    if (direct) begin
      xn = d_num; xe = d_err; xb = d_blank; xd = d_dp;
    end else begin
      xn = num_a[m_dig]; xe = err_a[m_dig]; xb = blank_a[m_dig]; xd = dp_a[m_dig];
    end
    x.tick = 1'b0;
    if (r) begin
      m_cnt = 0; m_dig = 0;
      x.an = 4'hF; x.seg = 7'h7F; x.dp_n = 1'b1;
    end else begin
      if (!e) m_cnt = 0;
      else if (m_cnt == P - 1) begin
        m_cnt  = 0;
        x.tick = (m_dig == 3);
        m_dig  = (m_dig + 1) % 4;
      end else m_cnt++;
      x.an = (e && m_cnt >= B) ? ~(4'b0001 << m_dig) : 4'hF;
      {x.dp_n, x.seg} = exp_out(xe, xb, xn, xd);
    end
    x.sel = 4'b0001 << m_dig;
    q.push_back(x);
    @(posedge clk);
    #1;
    x = q.pop_front();
    check("sel", sel, x.sel);
    check("an", an, x.an);
    check("seg", seg, x.seg);
    check("dp_n", dp_n, x.dp_n);
    check("frame_tick", frame_tick, x.tick);
    // Minimal-slot instance: one-hot select and an 8-cycle frame.
    cyc2++;
    check("sel2_onehot", $onehot(sel2), 1);
    if (!rst2 && tick2) begin
      if (n_tick2 > 0) check("tick2_gap", cyc2 - last2, 8);
      last2 = cyc2;
      n_tick2++;
    end
  endtask

  initial begin
    logic found;
    rst = 1'b1; en = 1'b0; rst2 = 1'b1; en2 = 1'b1;
    direct = 1'b0; d_num = 4'h0; d_err = 1'b0; d_blank = 1'b0; d_dp = 1'b0;
    num_a = '{4'h1, 4'h2, 4'h3, 4'h4};
    dp_a = '{1'b0, 1'b0, 1'b1, 1'b0};
    err_a = '{1'b0, 1'b0, 1'b0, 1'b0};
    blank_a = '{1'b0, 1'b0, 1'b0, 1'b0};
    af = '{7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_cnt = 0; m_dig = 0;

    // Reset state
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("rst_sel", sel, 4'b0001);
    check("rst_out", {an, seg, dp_n, frame_tick}, {4'hF, 7'h7F, 1'b1, 1'b0});
    rst2 = 1'b0;

    // Free-running scan over more than one frame with digits 1,2,3,4
    repeat (40) step(1'b0, 1'b1);

    // Decode priority and hex glyphs A..F
    direct = 1'b1;
    d_err = 1'b1; d_blank = 1'b1; d_num = 4'h8; d_dp = 1'b1;
    step(1'b0, 1'b1);
    check("prio_err", {dp_n, seg}, {1'b1, 7'b0000110});
    d_err = 1'b0;
    step(1'b0, 1'b1);
    check("prio_blank", {dp_n, seg}, {1'b1, 7'b1111111});
    d_blank = 1'b0; d_dp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      d_num = 4'(10 + i);
      step(1'b0, 1'b1);
      check("hex_af", seg, af[i]);
    end
    direct = 1'b0;

    // Drop enable at cnt=5 on digit 2
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_dig == 2 && m_cnt == 5) found = 1'b1;
      else step(1'b0, 1'b1);
    end
    check("reach_d2c5", found, 1'b1);
    step(1'b0, 1'b0);
    check("hold_sel", sel, 4'b0100);
    check("hold_an", an, 4'hF);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("reen_dead", an, 4'hF);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      check("reen_on", an, 4'b1011);
    end
    step(1'b0, 1'b1);
    check("reen_next", sel, 4'b1000);

    // Reset pulse mid-ON on digit 3
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (m_dig == 3 && m_cnt == 4) found = 1'b1;
      else step(1'b0, 1'b1);
    end
    check("reach_d3c4", found, 1'b1);
    step(1'b1, 1'b1);
    check("midrst", {sel, an, seg, dp_n, frame_tick},
          {4'b0001, 4'hF, 7'h7F, 1'b1, 1'b0});
    step(1'b0, 1'b1);
    check("post_rst_dead", an, 4'hF);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1);
      check("post_rst_on", an, 4'b1110);
    end
    repeat (40) step(1'b0, 1'b1);

    check("tick2_seen", n_tick2 >= 10, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the 4-digit 7-segment display. It generates the rotating one-hot digit select that feeds the 4:1 digit multiplexer's `S` input. It takes back the selected digit value, error, blank and decimal-point flags, and drives active-low segment and anode lines with a dead interval per slot to prevent ghosting. It sits between the calculator datapath muxing and the board pins.

## Interface
Parameters:
- `PRESCALE`, 50000: clk cycles per digit slot; legal range ≥ 2.
- `BLANK_CYCLES`, 2: dead cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYCLES < PRESCALE.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  display enable.
- `sel`  out  4  one-hot digit select, registered, drives mux `S`.
- `num`  in  4  selected digit value, 0–15.
- `err`  in  1  selected error flag.
- `blank`  in  1  selected blank flag.
- `dec_point`  in  1  selected decimal point.
- `an`  out  4  anodes, active-low, `an[i]` = digit i.
- `seg`  out  7  cathodes, active-low, {g,f,e,d,c,b,a}.
- `dp_n`  out  1  decimal-point cathode, active-low.
- `frame_tick`  out  1  one-cycle pulse per full 4-digit frame.

## Operation
- Reset values: `sel`=0001, `an`=1111, `seg`=1111111, `dp_n`=1, `frame_tick`=0, slot counter `cnt`=0.
- Slot counter:
  - `cnt` counts 0..PRESCALE-1 while `en`=1.
  - At `cnt`=PRESCALE-1, `cnt` goes to 0 and `sel` rotates left: 0001→0010→0100→1000→0001.
- Slot phases, decided from `cnt`:
  - DEAD (`cnt` < BLANK_CYCLES): `an`=1111.
  - ON (`cnt` ≥ BLANK_CYCLES): `an`=~`sel`.
  - `an` is registered and computed from the next-state `cnt`/`sel`, so it changes on the same edge as they do.
- Decode:
  - Registered every cycle from the current inputs. Priority is `err` > `blank` > `num`.
  - `err`=1: `seg`=0000110 ("E"), `dp_n`=1.
  - `blank`=1: `seg`=1111111, `dp_n`=1.
  - Otherwise `dp_n`=~`dec_point`, and `seg` is the hex glyph for `num`:
    - 0=1000000, 1=1111001, 2=0100100, 3=0110000
    - 4=0011001, 5=0010010, 6=0000010, 7=1111000
    - 8=0000000, 9=0010000, A=0001000, b=0000011
    - C=1000110, d=0100001, E=0000110, F=0001110
- `frame_tick`: asserted for exactly the one cycle in which `sel` first shows 0001 after 1000.
- `en`=0:
  - Next edge: `cnt`=0, `an`=1111, `frame_tick`=0.
  - `sel` holds its value. Decode keeps running.
  - When `en` returns to 1, the held digit restarts with a full slot, beginning with the DEAD phase.
- `rst` has priority over `en`. Asserting it mid-slot returns every output to its reset value on the next edge.

## Timing
- `sel`→`seg`/`dp_n` latency is 1 cycle: the mux is combinational, decode is registered. BLANK_CYCLES ≥ 1 ensures the anode is never lit while stale segments are present.
- Slot length is exactly PRESCALE cycles. The ON phase of every slot lasts PRESCALE-BLANK_CYCLES cycles.
- Frame period is 4·PRESCALE cycles; the `frame_tick` spacing is the same.
- Exactly one `an` bit is low during ON, and none during DEAD. `sel` is always one-hot, including after reset.
- Input changes within a slot appear on `seg` one cycle later. Nothing is latched per slot.

## Test plan
- PRESCALE=8, BLANK_CYCLES=2, `en`=1 after reset:
  - `sel` steps 0001, 0010, 0100, 1000, 0001 every 8 cycles.
  - `an` is 1111 for 2 cycles, then ~`sel` for 6 cycles.
  - `frame_tick` is high 1 cycle every 32 cycles.
- Mux model with num0..3 = 1, 2, 3, 4:
  - In each ON phase, `seg` = 1111001, 0100100, 0110000, 0011001 with the matching anode low.
  - `dec_point2`=1 gives `dp_n`=0 only during the digit-2 ON phase.
- Priority check:
  - `err`=1 with `blank`=1, `num`=8 → `seg`=0000110, `dp_n`=1.
  - `blank`=1, `num`=8, `dec_point`=1 → `seg`=1111111, `dp_n`=1.
  - `num`=A..F → 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Drop `en` at `cnt`=5 on digit 2:
  - Next edge: `an`=1111, `sel` holds 0100.
  - After re-enable: 2 dead cycles, then 6 ON cycles of digit 2, then `sel`=1000.
- Assert `rst` for 1 cycle mid-ON on digit 3:
  - Next edge: all outputs at their reset values.
  - The first slot after release is digit 0 with a full DEAD+ON sequence.
- Check with BLANK_CYCLES=1, PRESCALE=2:
  - Slot = 1 dead cycle + 1 ON cycle.
  - `sel` never non-one-hot, and `frame_tick` is high every 8 cycles.
